// File: rtl/fp_matmul_tile_seq_pkg.sv
// Shared definitions for the tiled Q8.8 matmul sequencer and related accumulating blocks.
package fp_matmul_tile_seq_pkg;

  localparam int unsigned Q_WIDTH = 16;

  localparam logic [Q_WIDTH-1:0] ONE     = 16'h0100;
  localparam logic [Q_WIDTH-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [Q_WIDTH-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MUL  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  // Signed 16-bit add clamped to the Q8.8 range instead of wrapping.
  function automatic logic [Q_WIDTH-1:0] sat_add16(input logic [Q_WIDTH-1:0] a,
                                                   input logic [Q_WIDTH-1:0] b);
    logic [Q_WIDTH:0] s;
    s = {a[Q_WIDTH-1], a} + {b[Q_WIDTH-1], b};
    if (s[Q_WIDTH] != s[Q_WIDTH-1]) begin
      return s[Q_WIDTH] ? SAT_MIN : SAT_MAX;
    end
    return s[Q_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/FPMatMul.sv
// Combinational fixed-point matrix multiply: exact dot products, floor-shifted by FRAC_BITS, saturated.
module FPMatMul #(
  parameter int unsigned INPUT_DATA_WIDTH  = 16,
  parameter int unsigned OUTPUT_DATA_WIDTH = 16,
  parameter int unsigned ROW_1             = 4,
  parameter int unsigned COL_1             = 4,
  parameter int unsigned ROW_2             = 4,
  parameter int unsigned COL_2             = 2,
  parameter int unsigned FRAC_BITS         = 8
) (
  input  logic [ROW_1*COL_1*INPUT_DATA_WIDTH-1:0]  input_1,
  input  logic [ROW_2*COL_2*INPUT_DATA_WIDTH-1:0]  input_2,
  output logic [ROW_1*COL_2*OUTPUT_DATA_WIDTH-1:0] output_data
);

  localparam int unsigned IW = INPUT_DATA_WIDTH;
  localparam int unsigned OW = OUTPUT_DATA_WIDTH;
  localparam int unsigned PW = 2 * IW;
  localparam int unsigned SW = PW + $clog2(COL_1) + 1;

  logic signed [IW-1:0] a_el;
  logic signed [IW-1:0] b_el;
  logic signed [PW-1:0] prod;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] scaled;

  always_comb begin
    output_data = '0;
    a_el        = '0;
    b_el        = '0;
    prod        = '0;
    sum         = '0;
    scaled      = '0;
    for (int unsigned i = 0; i < ROW_1; i++) begin
      for (int unsigned j = 0; j < COL_2; j++) begin
        sum = '0;
        for (int unsigned k = 0; k < COL_1; k++) begin
          a_el = input_1[(i*COL_1+k)*IW +: IW];
          b_el = input_2[(k*COL_2+j)*IW +: IW];
          prod = a_el * b_el;
          sum  = sum + SW'(prod);
        end
        scaled = sum >>> FRAC_BITS;
        // Fits when all bits above the output sign bit replicate it.
        if ((&scaled[SW-1:OW-1]) || !(|scaled[SW-1:OW-1])) begin
          output_data[(i*COL_2+j)*OW +: OW] = scaled[OW-1:0];
        end else begin
          output_data[(i*COL_2+j)*OW +: OW] = scaled[SW-1] ? {1'b1, {(OW-1){1'b0}}}
                                                            : {1'b0, {(OW-1){1'b1}}};
        end
      end
    end
  end

endmodule

// File: rtl/fp_matmul_tile_seq.sv
// Streams A/B tile pairs through one FPMatMul core and returns the saturating sum over k_tiles.
module fp_matmul_tile_seq
  import fp_matmul_tile_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROW        = 4,
  parameter int unsigned INNER      = 4,
  parameter int unsigned COL        = 2,
  parameter int unsigned KT_WIDTH   = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [KT_WIDTH-1:0]             k_tiles,
  input  logic                            a_valid,
  output logic                            a_ready,
  input  logic [ROW*INNER*DATA_WIDTH-1:0] a_data,
  input  logic                            b_valid,
  output logic                            b_ready,
  input  logic [INNER*COL*DATA_WIDTH-1:0] b_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ROW*COL*DATA_WIDTH-1:0]   out_data,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned AW   = ROW * INNER * DATA_WIDTH;
  localparam int unsigned BW   = INNER * COL * DATA_WIDTH;
  localparam int unsigned OW   = ROW * COL * DATA_WIDTH;
  localparam int unsigned NOUT = ROW * COL;

  state_e              state_q, state_d;
  logic                a_full_q, a_full_d;
  logic                b_full_q, b_full_d;
  logic [AW-1:0]       a_hold_q, a_hold_d;
  logic [BW-1:0]       b_hold_q, b_hold_d;
  logic [OW-1:0]       acc_q, acc_d;
  logic [KT_WIDTH-1:0] cnt_q, cnt_d;
  logic [OW-1:0]       core_out;
  logic                a_fire;
  logic                b_fire;

  FPMatMul #(
    .INPUT_DATA_WIDTH (DATA_WIDTH),
    .OUTPUT_DATA_WIDTH(DATA_WIDTH),
    .ROW_1            (ROW),
    .COL_1            (INNER),
    .ROW_2            (INNER),
    .COL_2            (COL)
  ) u_core (
    .input_1    (a_hold_q),
    .input_2    (b_hold_q),
    .output_data(core_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      a_hold_q <= '0;
      b_hold_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_full_q <= a_full_d;
      b_full_q <= b_full_d;
      a_hold_q <= a_hold_d;
      b_hold_q <= b_hold_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_full_d = a_full_q;
    b_full_d = b_full_q;
    a_hold_d = a_hold_q;
    b_hold_d = b_hold_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    a_fire   = 1'b0;
    b_fire   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d    = '0;
          cnt_d    = (k_tiles == '0) ? KT_WIDTH'(1) : k_tiles;
          a_full_d = 1'b0;
          b_full_d = 1'b0;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        a_fire = a_valid && !a_full_q;
        b_fire = b_valid && !b_full_q;
        if (a_fire) begin
          a_hold_d = a_data;
          a_full_d = 1'b1;
        end
        if (b_fire) begin
          b_hold_d = b_data;
          b_full_d = 1'b1;
        end
        // Move on at the edge that completes the pair, whichever arrived last.
        if ((a_full_q || a_fire) && (b_full_q || b_fire)) begin
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        for (int unsigned e = 0; e < NOUT; e++) begin
          acc_d[e*DATA_WIDTH +: DATA_WIDTH] = sat_add16(acc_q[e*DATA_WIDTH +: DATA_WIDTH],
                                                        core_out[e*DATA_WIDTH +: DATA_WIDTH]);
        end
        a_full_d = 1'b0;
        b_full_d = 1'b0;
        cnt_d    = cnt_q - KT_WIDTH'(1);
        state_d  = (cnt_q == KT_WIDTH'(1)) ? ST_OUT : ST_LOAD;
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign a_ready   = (state_q == ST_LOAD) && !a_full_q;
  assign b_ready   = (state_q == ST_LOAD) && !b_full_q;
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = acc_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_OUT) && out_ready;

endmodule

// File: tb/tb_fp_matmul_tile_seq.sv
// Randomized scoreboard bench for fp_matmul_tile_seq against an arithmetic reference model.
module tb_fp_matmul_tile_seq;
  import fp_matmul_tile_seq_pkg::*;

  localparam int unsigned DW = 16;
  localparam int unsigned R  = 4;
  localparam int unsigned N  = 4;
  localparam int unsigned C  = 2;
  localparam int unsigned KW = 8;
  localparam int unsigned AW = R * N * DW;
  localparam int unsigned BW = N * C * DW;
  localparam int unsigned OW = R * C * DW;

  logic          clk, rst, start;
  logic [KW-1:0] k_tiles;
  logic          a_valid, a_ready, b_valid, b_ready;
  logic [AW-1:0] a_data;
  logic [BW-1:0] b_data;
  logic          out_valid, out_ready, busy, done;
  logic [OW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int first_valid_cyc = 0;
  bit valid_seen = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int jobs_done = 0;

  logic [OW-1:0] exp_q[$];
  logic [AW-1:0] a_tiles[16];
  logic [BW-1:0] b_tiles[16];

  fp_matmul_tile_seq dut (
    .clk(clk), .rst(rst), .start(start), .k_tiles(k_tiles),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [OW-1:0] got, input logic [OW-1:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, expv);
    end
  endtask

  // Monitor: every presented result is compared with the head of the scoreboard.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (out_valid) begin
      if (!valid_seen) begin
        valid_seen = 1'b1;
        first_valid_cyc = cyc;
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got=%h", out_data);
      end else if (out_data !== exp_q[0]) begin
        errors++;
        $display("FAIL out_data got=%h exp=%h", out_data, exp_q[0]);
      end
      checks++;
      if (done !== out_ready) begin
        errors++;
        $display("FAIL done_pulse got=%b exp=%b", done, out_ready);
      end
      if (out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        hs_cnt++;
      end
    end
  end

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [OW-1:0] model(input int kt);
    longint acc[R*C];
    longint s;
    logic signed [DW-1:0] av, bv;
    logic [OW-1:0] r;
    for (int e = 0; e < R*C; e++) acc[e] = 0;
    for (int t = 0; t < kt; t++) begin
      for (int i = 0; i < R; i++) begin
        for (int j = 0; j < C; j++) begin
          s = 0;
          for (int k = 0; k < N; k++) begin
            av = a_tiles[t][(i*N+k)*DW +: DW];
            bv = b_tiles[t][(k*C+j)*DW +: DW];
            s = s + longint'(av) * longint'(bv);
          end
          acc[i*C+j] = clamp16(acc[i*C+j] + clamp16(s >>> 8));
        end
      end
    end
    r = '0;
    for (int e = 0; e < R*C; e++) r[e*DW +: DW] = 16'(acc[e]);
    return r;
  endfunction

  // kind 0: A=I, B=bval; 1: A=I, B=0x0100..0x0800; 2: random full range; 3: random small
  task automatic fill_tile(input int t, input int kind, input logic [15:0] bval);
    a_tiles[t] = '0;
    b_tiles[t] = '0;
    if (kind <= 1) begin
      for (int i = 0; i < R; i++) a_tiles[t][(i*N+i)*DW +: DW] = ONE;
      for (int e = 0; e < N*C; e++)
        b_tiles[t][e*DW +: DW] = (kind == 0) ? bval : 16'((e + 1) * 256);
    end else begin
      for (int e = 0; e < R*N; e++)
        a_tiles[t][e*DW +: DW] = (kind == 2) ? 16'($urandom) : 16'($urandom_range(0, 2048)) - 16'h0400;
      for (int e = 0; e < N*C; e++)
        b_tiles[t][e*DW +: DW] = (kind == 2) ? 16'($urandom) : 16'($urandom_range(0, 2048)) - 16'h0400;
    end
  endtask

  task automatic check_idle(input string name);
    chk({name, "_a_ready"},   OW'(a_ready),   '0);
    chk({name, "_b_ready"},   OW'(b_ready),   '0);
    chk({name, "_out_valid"}, OW'(out_valid), '0);
    chk({name, "_out_data"},  out_data,       '0);
    chk({name, "_busy"},      OW'(busy),      '0);
    chk({name, "_done"},      OW'(done),      '0);
  endtask

  task automatic start_job(input int kt);
    start = 1'b1;
    k_tiles = KW'(kt);
    start_cyc = cyc;
    valid_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_tile(input int t, input int b_lead);
    bit ad, bd, fa, fb;
    ad = 0; bd = 0;
    b_valid = 1'b1;
    b_data = b_tiles[t];
    for (int c = 0; c < 200 && !(ad && bd); c++) begin
      if (!ad && c >= b_lead) begin
        a_valid = 1'b1;
        a_data = a_tiles[t];
      end
      @(negedge clk);
      fa = a_valid && a_ready;
      fb = b_valid && b_ready;
      @(posedge clk); #1;
      if (fa) begin ad = 1; a_valid = 1'b0; end
      if (fb) begin bd = 1; b_valid = 1'b0; end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    checks++;
    if (!(ad && bd)) begin
      errors++;
      $display("FAIL tile_accept_timeout got=%0d%0d exp=11", ad, bd);
    end
  endtask

  task automatic do_job(input int kt, input int b_lead, input int stall, input bit spur);
    int kte, hs0;
    kte = (kt == 0) ? 1 : kt;
    hs0 = hs_cnt;
    exp_q.push_back(model(kte));
    out_ready = (stall == 0);
    start_job(kt);
    for (int t = 0; t < kte; t++) send_tile(t, b_lead);
    if (spur) begin
      start = 1'b1; k_tiles = 8'd7;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (stall > 0) begin
      for (int c = 0; c < 60 && !valid_seen; c++) @(posedge clk);
      repeat (stall) @(posedge clk);
      #1;
      if (spur) begin
        start = 1'b1; k_tiles = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
      end
      out_ready = 1'b1;
    end
    for (int c = 0; c < 100 && hs_cnt == hs0; c++) @(posedge clk);
    #1;
    checks++;
    if (hs_cnt == hs0) begin
      errors++;
      $display("FAIL result_timeout got=%0d exp=%0d", hs_cnt, hs0 + 1);
    end
    if (b_lead == 0)
      chk("out_valid_latency", OW'(first_valid_cyc - start_cyc), OW'(2 * kte + 1));
    jobs_done++;
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; k_tiles = '0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    fill_tile(0, 1, 16'h0);
    do_job(1, 0, 0, 0);

    for (int t = 0; t < 3; t++) fill_tile(t, 0, 16'h0080);
    do_job(3, 0, 0, 0);

    for (int t = 0; t < 2; t++) fill_tile(t, 0, 16'h6000);
    do_job(2, 0, 0, 0);
    for (int t = 0; t < 2; t++) fill_tile(t, 0, 16'hA000);
    do_job(2, 0, 0, 0);

    for (int t = 0; t < 2; t++) fill_tile(t, 3, 16'h0);
    do_job(2, 4, 0, 0);

    fill_tile(0, 2, 16'h0);
    do_job(1, 0, 5, 0);

    // Abort a job in the LOAD phase of its second tile; nothing is expected from it.
    for (int t = 0; t < 3; t++) fill_tile(t, 2, 16'h0);
    start_job(3);
    send_tile(0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("midjob_reset");
    @(posedge clk); #1;

    fill_tile(0, 1, 16'h0);
    fill_tile(1, 3, 16'h0);
    do_job(2, 0, 0, 0);

    fill_tile(0, 3, 16'h0);
    do_job(0, 0, 3, 1);

    for (int n = 0; n < 6; n++) begin
      int kt;
      kt = $urandom_range(1, 4);
      for (int t = 0; t < kt; t++) fill_tile(t, $urandom_range(2, 3), 16'h0);
      do_job(kt, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    chk("done_count", OW'(done_cnt), OW'(jobs_done));
    chk("scoreboard_empty", OW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
